// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution stream controller: widths,
// FSM state encoding and packing helpers for the 72-bit tap buses.
package conv_pkg;
  localparam int DATA_W = 8;
  localparam int OFM_W  = 21;
  localparam int TAPS   = 9;
  localparam int BUS_W  = TAPS * DATA_W;

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  // Replace byte slot k of a tap bus; slot k holds tap k+1.
  function automatic logic [BUS_W-1:0] put_tap(input logic [BUS_W-1:0] bus,
                                                input int unsigned k,
                                                input logic [DATA_W-1:0] v);
    logic [BUS_W-1:0] r;
    r = bus;
    r[k*DATA_W +: DATA_W] = v;
    return r;
  endfunction
endpackage

// File: rtl/conv_line_window.sv
// Two line buffers plus a 3x3 sliding window over a raster pixel stream;
// flags a complete (valid-padding) window one cycle after each qualifying accept.
module conv_line_window
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [DATA_W-1:0] pix_data,
  output logic              win_valid,
  output logic [BUS_W-1:0]  win,
  output logic              last_pix
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] tap_p1 [TAPS];
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              vld_p1;
  logic              col_end;
  logic              row_end;

  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign last_pix = accept && col_end && row_end;

  // Stage p1: window shift and line-buffer update on each accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row    <= '0;
      col    <= '0;
      vld_p1 <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        lb1[i] <= '0;
        lb2[i] <= '0;
      end
      for (int k = 0; k < TAPS; k++) tap_p1[k] <= '0;
    end else begin
      vld_p1 <= accept && (row >= RW'(2)) && (col >= CW'(2));
      if (clr) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        for (int g = 0; g < 3; g++) begin
          tap_p1[3*g]   <= tap_p1[3*g+1];
          tap_p1[3*g+1] <= tap_p1[3*g+2];
        end
        tap_p1[2] <= lb2[col];
        tap_p1[5] <= lb1[col];
        tap_p1[8] <= pix_data;
        lb2[col]  <= lb1[col];
        lb1[col]  <= pix_data;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < TAPS; k++) win[k*DATA_W +: DATA_W] = tap_p1[k];
  end

  assign win_valid = vld_p1;
endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: serial weight load,
// window issue from the pixel stream, result forwarding and completion.
module conv3x3_stream_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int LAT   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wt_valid,
  input  logic [7:0]        wt_data,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              conv_in_valid,
  output logic [71:0]       conv_ifm,
  output logic [71:0]       conv_weight,
  input  logic              conv_out_valid,
  input  logic [20:0]       conv_ofm,
  output logic              ofm_valid,
  output logic [20:0]       ofm_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int OUT_CNT = (IMG_W - 2) * (IMG_H - 2);
  localparam int OCW     = $clog2(OUT_CNT + 1);

  if (IMG_W < 3 || IMG_H < 3 || LAT < 1) begin : g_bad_param
    $error("conv3x3_stream_ctrl: IMG_W/IMG_H must be >= 3 and LAT >= 1");
  end

  state_t         state;
  logic [3:0]     wcnt;
  logic [OCW-1:0] ocnt;
  logic           accept;
  logic           last_pix;
  logic           frame_clr;
  logic           expect_res;
  logic           fwd;

  assign pix_ready  = (state == STREAM);
  assign busy       = (state != IDLE);
  assign accept     = pix_valid && pix_ready;
  assign frame_clr  = (state == IDLE) && start;
  assign expect_res = ((state == STREAM) || (state == DRAIN)) && (ocnt < OCW'(OUT_CNT));
  assign fwd        = conv_out_valid && expect_res;

  conv_line_window #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (frame_clr),
    .accept   (accept),
    .pix_data (pix_data),
    .win_valid(conv_in_valid),
    .win      (conv_ifm),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      ocnt        <= '0;
      conv_weight <= '0;
      ofm_valid   <= 1'b0;
      ofm_data    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      ofm_valid <= fwd;
      done      <= 1'b0;
      if (fwd) begin
        ofm_data <= conv_ofm;
        ocnt     <= ocnt + OCW'(1);
      end
      case (state)
        IDLE: if (start) begin
          state <= LOAD_W;
          wcnt  <= '0;
          ocnt  <= '0;
          err   <= 1'b0;
        end
        LOAD_W: if (wt_valid) begin
          conv_weight <= put_tap(conv_weight, wcnt, wt_data);
          wcnt        <= wcnt + 4'd1;
          if (wcnt == 4'd8) state <= STREAM;
        end
        STREAM: if (last_pix) state <= DRAIN;
        // The final forward and the DONE transition share an edge so done
        // lands one cycle after the last datapath result.
        DRAIN: if (ocnt + OCW'(fwd) == OCW'(OUT_CNT)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (conv_out_valid && !expect_res) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Bench for conv3x3_stream_ctrl on a 4x4 image with a LAT=3 datapath model.
module tb_conv3x3_stream_ctrl;
  localparam int W = 4, H = 4, LAT = 3, NPIX = W * H, NOUT = (W - 2) * (H - 2);

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, wt_valid = 1'b0;
  logic        pix_valid = 1'b0, inj = 1'b0;
  logic [7:0]  wt_data = '0, pix_data = '0;
  logic        pix_ready, conv_in_valid, conv_out_valid, ofm_valid, busy, done, err;
  logic [71:0] conv_ifm, conv_weight;
  logic [20:0] conv_ofm, ofm_data;

  always #5 clk = ~clk;

  conv3x3_stream_ctrl #(.IMG_W(W), .IMG_H(H), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wt_valid(wt_valid), .wt_data(wt_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .conv_in_valid(conv_in_valid), .conv_ifm(conv_ifm), .conv_weight(conv_weight),
    .conv_out_valid(conv_out_valid), .conv_ofm(conv_ofm), .ofm_valid(ofm_valid),
    .ofm_data(ofm_data), .busy(busy), .done(done), .err(err)
  );

  // Datapath stand-in: multiply-accumulate with LAT cycles of delay
  function automatic logic [20:0] dot(input logic [71:0] a, input logic [71:0] b);
    int unsigned s = 0;
    for (int k = 0; k < 9; k++) s += a[8*k +: 8] * b[8*k +: 8];
    return 21'(s);
  endfunction

  logic [LAT-1:0] dp_v;
  logic [20:0]    dp_d [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_v <= '0;
      for (int i = 0; i < LAT; i++) dp_d[i] <= '0;
    end else begin
      dp_v    <= {dp_v[LAT-2:0], conv_in_valid};
      dp_d[0] <= dot(conv_ifm, conv_weight);
      for (int i = 1; i < LAT; i++) dp_d[i] <= dp_d[i-1];
    end
  end
  assign conv_out_valid = dp_v[LAT-1] | inj;
  assign conv_ofm       = dp_d[LAT-1];

  int vectors = 0, errs = 0, fr = 0;
  int unsigned img [NPIX];
  logic [7:0]  wts [9];
  int unsigned exp_q [$];
  int unsigned got [$];
  int cyc = 0, n_acc, n_win, n_consec, n_done, last_acc, done_cyc, wchg;
  bit prev_win, wsnap_ok;
  logic [71:0] wsnap;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin n_acc++; last_acc = cyc; end
    if (conv_in_valid) begin n_win++; if (prev_win) n_consec++; end
    prev_win = conv_in_valid;
    if (ofm_valid) got.push_back(ofm_data);
    if (wsnap_ok && conv_weight !== wsnap) wchg++;
    if (done) begin n_done++; done_cyc = cyc; wsnap_ok = 0; end
    else if (pix_ready && !wsnap_ok) begin wsnap = conv_weight; wsnap_ok = 1; end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL frame%0d %s: observed %0h expected %0h", fr, tag, obs, expv);
    end
  endtask

  // Valid-padding 3x3 correlation computed directly from the image and weights
  function automatic void ref_model();
    exp_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        int unsigned s = 0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            s += img[(r-2+dr)*W + (c-2+dc)] * wts[dr*3+dc];
        exp_q.push_back(s);
      end
  endfunction

  function automatic logic [71:0] packed_wts();
    logic [71:0] p;
    for (int k = 0; k < 9; k++) p[8*k +: 8] = wts[k];
    return p;
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clr_mon();
    n_acc = 0; n_win = 0; n_consec = 0; n_done = 0; wchg = 0;
    last_acc = 0; done_cyc = 0; wsnap_ok = 0; got.delete();
  endtask

  task automatic set_frame(input int kind);
    for (int i = 0; i < NPIX; i++)
      img[i] = (kind == 0) ? i + 1 : (kind == 2) ? 255 : $urandom_range(0, 255);
    for (int k = 0; k < 9; k++)
      wts[k] = (kind == 0) ? 8'd1 : (kind == 1) ? ((k == 4) ? 8'd1 : 8'd0) :
               (kind == 2) ? 8'd255 : 8'($urandom_range(0, 255));
    if (kind == 1) for (int i = 0; i < NPIX; i++) img[i] = i + 1;
    ref_model();
    clr_mon();
  endtask

  task automatic load_frame();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wt_valid = 1'b1; wt_data = wts[k]; tick();
    end
    wt_valid = 1'b0;
  endtask

  task automatic stream(input bit gaps, input bit poke, input int abort_at, input bit hold);
    int idx = 0, guard = 0;
    bit rdy, pv;
    while (idx < NPIX && guard < 400) begin
      if (abort_at >= 0 && idx == abort_at) begin pix_valid = 1'b0; return; end
      rdy = pix_ready;
      pv = !(gaps && (guard % 2 == 1));
      pix_valid = pv; pix_data = img[idx][7:0];
      if (poke && idx == 5) begin start = 1'b1; wt_valid = 1'b1; wt_data = 8'h5a; end
      tick();
      start = 1'b0; wt_valid = 1'b0;
      if (pv && rdy) idx++;
      guard++;
    end
    check("pixels_sent", idx, NPIX);
    pix_valid = hold; pix_data = 8'haa;
    if (hold) check("drain_ready", pix_ready, 0);
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done == 0 && k < 60) begin tick(); k++; end
    repeat (4) tick();
    pix_valid = 1'b0;
  endtask

  task automatic check_results();
    check("n_ofm", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [71:0] v = 'x;
      if (i < got.size()) v = got[i];
      check("ofm", v, exp_q[i]);
    end
    check("n_done", n_done, 1);
    check("done_lat", done_cyc - last_acc, LAT + 2);
    check("err", err, 0);
    check("n_win", n_win, NOUT);
    check("n_acc", n_acc, NPIX);
    check("wt_stable", wchg, 0);
    check("wt_bus", conv_weight, packed_wts());
    check("idle_busy", busy, 0);
  endtask

  task automatic check_zero_outputs();
    check("z_busy", busy, 0);           check("z_ready", pix_ready, 0);
    check("z_inval", conv_in_valid, 0); check("z_ifm", conv_ifm, 0);
    check("z_wt", conv_weight, 0);      check("z_ofmv", ofm_valid, 0);
    check("z_ofm", ofm_data, 0);        check("z_done", done, 0);
    check("z_err", err, 0);
  endtask

  initial begin
    #1 check_zero_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    fr = 1; set_frame(0); load_frame(); stream(0, 0, -1, 0); wait_done(); check_results();

    fr = 2; set_frame(1); load_frame(); stream(1, 0, -1, 0); wait_done(); check_results();
    check("no_consec_win", n_consec, 0);

    fr = 3; set_frame(2); load_frame(); stream(0, 0, -1, 1); wait_done(); check_results();

    fr = 4; set_frame(0);
    wt_valid = 1'b1; wt_data = 8'h77; tick(); wt_valid = 1'b0;
    check("idle_wt_busy", busy, 0);
    load_frame(); stream(0, 1, -1, 0); wait_done(); check_results();

    fr = 5; clr_mon();
    inj = 1'b1; tick(); inj = 1'b0; tick();
    check("inj_err", err, 1);
    check("inj_fwd", got.size(), 0);
    check("inj_busy", busy, 0);
    set_frame(3); load_frame();
    check("err_clr", err, 0);
    stream(0, 0, -1, 0); wait_done(); check_results();

    fr = 6; set_frame(0); load_frame(); stream(0, 0, 8, 0);
    rst_n = 1'b0;
    #1 check_zero_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) tick();
    check("abort_done", n_done, 0);
    check("abort_busy", busy, 0);
    set_frame(0); load_frame(); stream(0, 0, -1, 0); wait_done(); check_results();

    for (int f = 0; f < 3; f++) begin
      fr = 7 + f; set_frame(3); load_frame();
      stream(1'($urandom_range(0, 1)), 0, -1, 1'($urandom_range(0, 1)));
      wait_done(); check_results();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
